// File: rtl/decode_inst_queue.sv
// N-in/M-out decoded-instruction queue between decode and dispatch: compacts sparse
// enqueue slots in program order and exposes the oldest entries. Optional perf counters: DECODE_QUEUE_PERF_EN.
module decode_inst_queue #(
   parameter int DATA_WIDTH = 126,
   parameter int DEPTH      = 8,
   parameter int ENQ_WIDTH  = 2,
   parameter int DEQ_WIDTH  = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            flush,
   input  logic [ENQ_WIDTH-1:0]            enq_valid,
   input  logic [ENQ_WIDTH*DATA_WIDTH-1:0] enq_data,
   output logic                            enq_ready,
   output logic [DEQ_WIDTH-1:0]            deq_valid,
   output logic [DEQ_WIDTH*DATA_WIDTH-1:0] deq_data,
   input  logic [DEQ_WIDTH-1:0]            deq_ack,
   output logic [$clog2(DEPTH):0]          count,
   output logic                            full,
   output logic                            empty,
   output logic                            get_data_req
`ifdef DECODE_QUEUE_PERF_EN
   ,
   output logic [31:0]                     stall_cycles,
   output logic [31:0]                     empty_cycles
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ENQ_C   = CNT_W'(ENQ_WIDTH);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      head_q, head_d;
   logic [PTR_W-1:0]      tail_q, tail_d;
   logic [CNT_W-1:0]      count_q, count_d;

   logic                  enq_fire;
   logic [CNT_W-1:0]      push, push_eff, pop;
   logic [PTR_W-1:0]      wr_idx [ENQ_WIDTH];
   logic [PTR_W-1:0]      rd_idx [DEQ_WIDTH];
   logic                  ack_run;

   // Space check uses registered count only; same-cycle pops never free room.
   assign enq_ready    = (DEPTH_C - count_q) >= ENQ_C;
   assign get_data_req = enq_ready;
   assign enq_fire     = enq_ready && !flush;
   assign count        = count_q;
   assign full         = (count_q == DEPTH_C);
   assign empty        = (count_q == '0);

   // Each valid slot lands at tail plus the number of valid slots below it.
   always_comb begin
      push = '0;
      for (int i = 0; i < ENQ_WIDTH; i++) begin
         wr_idx[i] = tail_q + push[PTR_W-1:0];
         if (enq_valid[i]) push = push + ONE_C;
      end
      push_eff = enq_fire ? push : '0;
   end

   always_comb begin
      pop     = '0;
      ack_run = 1'b1;
      for (int i = 0; i < DEQ_WIDTH; i++) begin
         deq_valid[i] = count_q > CNT_W'(i);
         rd_idx[i]    = head_q + PTR_W'(i);
         deq_data[i*DATA_WIDTH +: DATA_WIDTH] = deq_valid[i] ? mem_q[rd_idx[i]] : '0;
         ack_run = ack_run && deq_ack[i] && deq_valid[i];
         if (ack_run) pop = pop + ONE_C;
      end
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + pop[PTR_W-1:0];
         tail_d  = tail_q + push_eff[PTR_W-1:0];
         count_d = count_q + push_eff - pop;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (enq_fire) begin
         for (int i = 0; i < ENQ_WIDTH; i++) begin
            if (enq_valid[i]) mem_q[wr_idx[i]] <= enq_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

`ifdef DECODE_QUEUE_PERF_EN
   logic [31:0] stall_q, empty_q;

   // Both counters saturate and survive flush; only rst clears them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
         empty_q <= '0;
      end else begin
         if ((|enq_valid) && !enq_ready && !flush && (stall_q != 32'hFFFF_FFFF))
            stall_q <= stall_q + 32'd1;
         if (empty && !flush && (empty_q != 32'hFFFF_FFFF))
            empty_q <= empty_q + 32'd1;
      end
   end

   assign stall_cycles = stall_q;
   assign empty_cycles = empty_q;
`endif

   a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= DEPTH_C);
   a_pop_bound:   assert property (@(posedge clk) disable iff (rst) pop <= count_q);

endmodule
